// File: rtl/rom_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rom_pkg
// Shared definitions for the cartridge ROM arbiter slice.
//   ROM_ADDR_W / ROM_DATA_W : geometry of blk_mem_gen_0 (18-bit addr, 24-bit data)
//   req_id_t                : requester identifier carried down the tag pipeline
//   STARVE_CNT_W            : width of the starvation counter (covers 1..255)
// ---------------------------------------------------------------------------
package rom_pkg;

   localparam int ROM_ADDR_W   = 18;
   localparam int ROM_DATA_W   = 24;
   localparam int STARVE_CNT_W = 8;

   typedef enum logic {
      REQ_CORE = 1'b0,   // MainGameBoy core fetch port
      REQ_AUX  = 1'b1    // secondary reader (tile/debug viewer or loader)
   } req_id_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// ---------------------------------------------------------------------------
// rom_arbiter_if
// One requester's read port onto the shared ROM.
//   req    : read request, held until gnt
//   addr   : read address, stable while req is high and ungranted
//   gnt    : combinational accept in the current cycle
//   rvalid : rdata valid this cycle (one pulse per accepted request)
//   rdata  : read data, meaningful only while rvalid is high
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rom_arbiter_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 24
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/rom_arbiter_tag_pipe.sv
// ---------------------------------------------------------------------------
// rom_tag_pipe
// Shift register of {valid, id} that tracks each read from acceptance until
// its data appears on the ROM output.
//   clk, rst_n : clock, asynchronous active-low clear
//   in_valid   : a read was accepted this cycle
//   in_id      : owner of the accepted read
//   out_valid  : last stage valid (read data is on the ROM output now)
//   out_id     : owner of the read in the last stage
//   any_valid  : at least one stage holds a read in flight
// ---------------------------------------------------------------------------
module rom_tag_pipe
   import rom_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    in_valid,
   input  req_id_t in_id,
   output logic    out_valid,
   output req_id_t out_id,
   output logic    any_valid
);

   logic [DEPTH-1:0] valid_reg;
   req_id_t          id_reg [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  valid_reg[gi] <= 1'b0;
                  id_reg[gi]    <= REQ_CORE;
               end else begin
                  valid_reg[gi] <= in_valid;
                  id_reg[gi]    <= in_id;
               end
            end
         end else begin : g_body
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  valid_reg[gi] <= 1'b0;
                  id_reg[gi]    <= REQ_CORE;
               end else begin
                  valid_reg[gi] <= valid_reg[gi-1];
                  id_reg[gi]    <= id_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   assign out_valid = valid_reg[DEPTH-1];
   assign out_id    = id_reg[DEPTH-1];
   assign any_valid = |valid_reg;

endmodule

// File: rtl/rom_arbiter.sv
// ---------------------------------------------------------------------------
// rom_arbiter
// Shares the single-port synchronous cartridge ROM between the core fetch
// port (rq0) and a secondary reader (rq1). One read accepted per cycle,
// responses return in acceptance order after a fixed latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   rq0, rq1   : requester ports (req/addr/gnt/rvalid/rdata)
//   rom_addr   : registered address to ROM addra
//   rom_dout   : ROM douta
//   busy       : at least one read in flight
// Parameters: READ_LAT (1..3) ROM latency, PRIO0 (1 = fixed priority to rq0
// with starvation guard, 0 = round-robin), STARVE_MAX (1..255).
// ---------------------------------------------------------------------------
module rom_arbiter
   import rom_pkg::*;
#(
   parameter int ADDR_W     = ROM_ADDR_W,
   parameter int DATA_W     = ROM_DATA_W,
   parameter int READ_LAT   = 1,
   parameter int PRIO0      = 1,
   parameter int STARVE_MAX = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   rom_arbiter_if.slave        rq0,
   rom_arbiter_if.slave        rq1,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [DATA_W-1:0]   rom_dout,
   output logic                busy
);

   localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

   logic                    gnt0;
   logic                    gnt1;
   logic                    accept;
   req_id_t                 acc_id;
   req_id_t                 last_grant_reg;
   logic [STARVE_CNT_W-1:0] starve_cnt_reg;
   logic [STARVE_CNT_W-1:0] starve_cnt_next;
   logic [ADDR_W-1:0]       rom_addr_reg;
   logic                    starve_hit;
   logic                    pipe_valid;
   req_id_t                 pipe_id;

   assign starve_hit = (starve_cnt_reg == STARVE_LIM);

   // Grant is combinational so a requester can be accepted in the cycle it
   // raises req. Each branch derives gnt1 from gnt0 (or vice versa) so the
   // two can never be high together.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (PRIO0 != 0) begin
         gnt1 = rq1.req & (~rq0.req | starve_hit);
         gnt0 = rq0.req & ~gnt1;
      end else begin
         gnt0 = rq0.req & (~rq1.req | (last_grant_reg == REQ_AUX));
         gnt1 = rq1.req & ~gnt0;
      end
   end

   assign accept = gnt0 | gnt1;
   assign acc_id = gnt1 ? REQ_AUX : REQ_CORE;

   // Counts cycles rq1 waits behind rq0; saturates so the forced grant fires
   // on the cycle after STARVE_MAX waiting cycles.
   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (PRIO0 == 0) begin
         starve_cnt_next = '0;
      end else if (!rq1.req || gnt1) begin
         starve_cnt_next = '0;
      end else if (!starve_hit) begin
         starve_cnt_next = starve_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr_reg   <= '0;
         last_grant_reg <= REQ_AUX;   // so rq0 wins the first round-robin tie
         starve_cnt_reg <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
         if (accept) begin
            rom_addr_reg   <= gnt1 ? rq1.addr : rq0.addr;
            last_grant_reg <= acc_id;
         end
      end
   end

   // Stage 0 covers the rom_addr register, the remaining READ_LAT stages
   // cover the ROM itself.
   rom_tag_pipe #(
      .DEPTH (READ_LAT + 1)
   ) u_tag_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (accept),
      .in_id     (acc_id),
      .out_valid (pipe_valid),
      .out_id    (pipe_id),
      .any_valid (busy)
   );

   assign rom_addr   = rom_addr_reg;
   assign rq0.gnt    = gnt0;
   assign rq1.gnt    = gnt1;
   assign rq0.rvalid = pipe_valid & (pipe_id == REQ_CORE);
   assign rq1.rvalid = pipe_valid & (pipe_id == REQ_AUX);
   assign rq0.rdata  = rom_dout;
   assign rq1.rdata  = rom_dout;

endmodule

// File: tb/tb_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_arbiter
// Three arbiter instances sharing clk/rst_n:
//   dut_a : READ_LAT=1, PRIO0=1, STARVE_MAX=8
//   dut_b : READ_LAT=1, PRIO0=0 (round-robin)
//   dut_c : READ_LAT=2, PRIO0=1
// Each has a behavioural ROM whose contents are rom_f(addr).
// ---------------------------------------------------------------------------
module tb_rom_arbiter;
   import rom_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks_cnt = 0;
   int errors_cnt = 0;

   rom_arbiter_if #(.ADDR_W(18), .DATA_W(24)) ia0 ();
   rom_arbiter_if #(.ADDR_W(18), .DATA_W(24)) ia1 ();
   rom_arbiter_if #(.ADDR_W(18), .DATA_W(24)) ib0 ();
   rom_arbiter_if #(.ADDR_W(18), .DATA_W(24)) ib1 ();
   rom_arbiter_if #(.ADDR_W(18), .DATA_W(24)) ic0 ();
   rom_arbiter_if #(.ADDR_W(18), .DATA_W(24)) ic1 ();

   logic [17:0] rom_addr_a, rom_addr_b, rom_addr_c;
   logic [23:0] rom_dout_a, rom_dout_b, rom_dout_c;
   logic [23:0] rom_c_q0;
   logic        busy_a, busy_b, busy_c;

   function automatic logic [23:0] rom_f(input logic [17:0] a);
      return {a[5:0], a} ^ 24'h5A5A5A;
   endfunction

   // Behavioural synchronous ROMs, one and two cycles of latency.
   always @(posedge clk) rom_dout_a <= rom_f(rom_addr_a);
   always @(posedge clk) rom_dout_b <= rom_f(rom_addr_b);
   always @(posedge clk) begin
      rom_c_q0   <= rom_f(rom_addr_c);
      rom_dout_c <= rom_c_q0;
   end

   rom_arbiter #(.READ_LAT(1), .PRIO0(1), .STARVE_MAX(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .rq0(ia0), .rq1(ia1),
      .rom_addr(rom_addr_a), .rom_dout(rom_dout_a), .busy(busy_a));

   rom_arbiter #(.READ_LAT(1), .PRIO0(0), .STARVE_MAX(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .rq0(ib0), .rq1(ib1),
      .rom_addr(rom_addr_b), .rom_dout(rom_dout_b), .busy(busy_b));

   rom_arbiter #(.READ_LAT(2), .PRIO0(1), .STARVE_MAX(8)) dut_c (
      .clk(clk), .rst_n(rst_n), .rq0(ic0), .rq1(ic1),
      .rom_addr(rom_addr_c), .rom_dout(rom_dout_c), .busy(busy_c));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n0;
      int n1;
      ia0.req = 0; ia0.addr = '0; ia1.req = 0; ia1.addr = '0;
      ib0.req = 0; ib0.addr = '0; ib1.req = 0; ib1.addr = '0;
      ic0.req = 0; ic0.addr = '0; ic1.req = 0; ic1.addr = '0;

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      #1;
      check_val("rst_rom_addr_a", 32'(rom_addr_a), 32'h0);
      check_val("rst_busy_a", 32'(busy_a), 32'h0);
      check_val("rst_rvalid0_a", 32'(ia0.rvalid), 32'h0);
      check_val("rst_rvalid1_a", 32'(ia1.rvalid), 32'h0);
      check_val("rst_gnt0_a", 32'(ia0.gnt), 32'h0);
      check_val("rst_busy_c", 32'(busy_c), 32'h0);
      cyc();

      // Single read on requester 0
      $display("txn dut_a req0 addr=00100");
      ia0.req = 1; ia0.addr = 18'h00100;
      #1;
      check_val("t1_gnt0", 32'(ia0.gnt), 32'h1);
      check_val("t1_gnt1", 32'(ia1.gnt), 32'h0);
      cyc();
      ia0.req = 0;
      #1;
      check_val("t1_rom_addr", 32'(rom_addr_a), 32'h00100);
      check_val("t1_rvalid0_early", 32'(ia0.rvalid), 32'h0);
      check_val("t1_busy", 32'(busy_a), 32'h1);
      cyc();
      #1;
      check_val("t1_rvalid0", 32'(ia0.rvalid), 32'h1);
      check_val("t1_rdata0", 32'(ia0.rdata), 32'(rom_f(18'h00100)));
      check_val("t1_rvalid1", 32'(ia1.rvalid), 32'h0);
      cyc();
      #1;
      check_val("t1_rvalid0_after", 32'(ia0.rvalid), 32'h0);
      check_val("t1_busy_after", 32'(busy_a), 32'h0);
      cyc();

      // Back-to-back reads of addresses 0..3
      for (int c = 0; c < 8; c++) begin
         if (c < 4) begin
            $display("txn dut_a req0 addr=%05h", c);
            ia0.req = 1; ia0.addr = 18'(c);
         end else begin
            ia0.req = 0;
         end
         #1;
         if (c < 4) check_val("t2_gnt0", 32'(ia0.gnt), 32'h1);
         check_val("t2_rvalid0", 32'(ia0.rvalid), 32'((c >= 2) && (c <= 5)));
         if ((c >= 2) && (c <= 5))
            check_val("t2_rdata0", 32'(ia0.rdata), 32'(rom_f(18'(c - 2))));
         check_val("t2_busy", 32'(busy_a), 32'((c >= 1) && (c <= 5)));
         cyc();
      end

      // Fixed priority with starvation guard: 8 x gnt0 then gnt1, repeating
      $display("txn dut_a req0+req1 held 18 cycles");
      ia0.req = 1; ia0.addr = 18'h00200;
      ia1.req = 1; ia1.addr = 18'h00300;
      for (int c = 0; c < 18; c++) begin
         #1;
         check_val("t3_gnt1", 32'(ia1.gnt), 32'((c % 9) == 8));
         check_val("t3_gnt0", 32'(ia0.gnt), 32'((c % 9) != 8));
         cyc();
      end
      ia0.req = 0; ia1.req = 0;
      repeat (3) cyc();

      // Round-robin from reset: 0,1,0,1...
      n0 = 0; n1 = 0;
      for (int c = 0; c < 10; c++) begin
         if (c < 8) begin
            $display("txn dut_b req0 addr=%05h req1 addr=%05h", 18'h00A00 + n0, 18'h00B00 + n1);
            ib0.req = 1; ib0.addr = 18'(18'h00A00 + n0);
            ib1.req = 1; ib1.addr = 18'(18'h00B00 + n1);
         end else begin
            ib0.req = 0; ib1.req = 0;
         end
         #1;
         if (c < 8) begin
            check_val("t4_gnt0", 32'(ib0.gnt), 32'((c % 2) == 0));
            check_val("t4_gnt1", 32'(ib1.gnt), 32'((c % 2) == 1));
            if ((c % 2) == 0) n0++; else n1++;
         end
         check_val("t4_rvalid0", 32'(ib0.rvalid), 32'((c >= 2) && ((c % 2) == 0)));
         check_val("t4_rvalid1", 32'(ib1.rvalid), 32'((c >= 3) && ((c % 2) == 1)));
         if ((c >= 2) && ((c % 2) == 0))
            check_val("t4_rdata0", 32'(ib0.rdata), 32'(rom_f(18'(18'h00A00 + (c - 2) / 2))));
         if ((c >= 3) && ((c % 2) == 1))
            check_val("t4_rdata1", 32'(ib1.rdata), 32'(rom_f(18'(18'h00B00 + (c - 3) / 2))));
         check_val("t4_busy", 32'(busy_b), 32'((c >= 1) && (c <= 9)));
         cyc();
      end

      // Max address accepted on requester 1, then reset while in flight
      $display("txn dut_a req1 addr=3ffff then reset");
      ia1.req = 1; ia1.addr = 18'h3FFFF;
      #1;
      check_val("t5_gnt1", 32'(ia1.gnt), 32'h1);
      check_val("t5_gnt0", 32'(ia0.gnt), 32'h0);
      cyc();
      ia1.req = 0;
      #1;
      check_val("t5_rom_addr", 32'(rom_addr_a), 32'h3FFFF);
      check_val("t5_busy", 32'(busy_a), 32'h1);
      rst_n = 1'b0;
      #1;
      check_val("t5_rst_rom_addr", 32'(rom_addr_a), 32'h0);
      check_val("t5_rst_busy", 32'(busy_a), 32'h0);
      cyc();
      cyc();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         check_val("t5_rvalid1", 32'(ia1.rvalid), 32'h0);
         check_val("t5_busy_post", 32'(busy_a), 32'h0);
         check_val("t5_rom_addr_post", 32'(rom_addr_a), 32'h0);
         cyc();
      end

      // READ_LAT=2 instance, single read on requester 1
      $display("txn dut_c req1 addr=12345");
      ic1.req = 1; ic1.addr = 18'h12345;
      #1;
      check_val("t6_gnt1", 32'(ic1.gnt), 32'h1);
      check_val("t6_gnt0", 32'(ic0.gnt), 32'h0);
      cyc();
      ic1.req = 0;
      for (int c = 1; c <= 4; c++) begin
         #1;
         check_val("t6_rvalid1", 32'(ic1.rvalid), 32'(c == 3));
         check_val("t6_rvalid0", 32'(ic0.rvalid), 32'h0);
         if (c == 3) check_val("t6_rdata1", 32'(ic1.rdata), 32'(rom_f(18'h12345)));
         if (c == 1) check_val("t6_rom_addr", 32'(rom_addr_c), 32'h12345);
         check_val("t6_busy", 32'(busy_c), 32'(c <= 3));
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single-port cartridge ROM (blk_mem_gen_0, 18-bit address, 24-bit data, synchronous read) between two requesters.
- Requester 0 is the MainGameBoy core fetch port; requester 1 is a secondary reader (display tile/debug viewer or loader).
- Accepts at most one read per cycle, pipelined. Returns read data to the owning requester with a fixed latency, tagged by a per-requester valid.
- Sits in top between the requesters and the ROM instance, on clk.

Parameters:
- ADDR_W, 18, ROM address width.
- DATA_W, 24, ROM data width.
- READ_LAT, 1, ROM read latency in cycles from address sampled to douta valid; legal range 1..3.
- PRIO0, 1: 1 = requester 0 has fixed priority with starvation guard; 0 = pure round-robin.
- STARVE_MAX, 8, cycles requester 1 may wait under PRIO0=1 before a forced grant; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 read request, held until gnt0
- addr0  in  ADDR_W  requester 0 address, stable while req0 is high
- gnt0  out  1  combinational accept for requester 0 this cycle
- rvalid0  out  1  rdata0 valid this cycle
- rdata0  out  DATA_W  read data for requester 0
- req1 / addr1 / gnt1 / rvalid1 / rdata1: same as requester 0, for requester 1
- rom_addr  out  ADDR_W  registered address to ROM addra
- rom_dout  in  DATA_W  ROM douta
- busy  out  1  at least one read in flight

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - rom_addr = 0.
  - Tag pipeline cleared; rvalid0 = rvalid1 = 0; busy = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - starve_cnt = 0.
- Reset mid-operation: in-flight reads are discarded. No rvalid is produced for them after rst_n deasserts.
- Grant, cycle T (combinational from req, last_grant, starve_cnt):
  - Only req0 high: gnt0. Only req1 high: gnt1. Neither: no grant.
  - Both high, PRIO0=0: grant the requester that is not last_grant.
  - Both high, PRIO0=1: gnt0, unless starve_cnt == STARVE_MAX, in which case gnt1.
  - gnt0 and gnt1 are never both high.
  - A grant while req is low is illegal.
- Acceptance at the end of cycle T (req & gnt):
  - rom_addr <= granted addr.
  - The tag pipeline stage 0 records {valid=1, id}.
  - last_grant <= id.
- Pipeline: the tag pipeline has READ_LAT+1 stages. The requester's rvalid goes high in cycle T+1+READ_LAT, for exactly one cycle per accepted request.
- Read data: rdata0 and rdata1 are both driven from rom_dout unregistered. They are only meaningful when the matching rvalid is high.
- Throughput: one accept per cycle, back-to-back. Responses return in acceptance order.
- Idle cycles: rom_addr holds its last value.
- starve_cnt (PRIO0=1 only):
  - Increments each cycle req1 is high and gnt1 is low, saturating at STARVE_MAX.
  - Clears on gnt1, or when req1 is low.
  - When PRIO0=0, starve_cnt is held at 0.
- busy = OR of the valid bits across all tag pipeline stages.
- Requester contract: addr must not change while req is high and ungranted. A dropped req before grant is tolerated; no read is issued.

Decomposition:
- Shared package rom_pkg:
  - ROM_ADDR_W = 18, ROM_DATA_W = 24.
  - Requester-id type (1 bit) with constants REQ_CORE = 0 and REQ_AUX = 1.
- Sub-module rom_tag_pipe: parameterised-depth shift register of {valid, id}, with async clear and an any-valid output. It produces rvalid0/rvalid1 and busy.

Test Plan:
- Reset, then req0 at addr 0x00100 in cycle 2 -> gnt0 in cycle 2; rom_addr = 0x00100 in cycle 3; rvalid0 in cycle 4 (READ_LAT=1) with rdata0 = ROM[0x00100]; rvalid1 stays 0.
- req0 held high with addresses 0,1,2,3 on consecutive cycles -> four gnt0 cycles and four consecutive rvalid0 pulses carrying ROM[0..3] in order; busy high throughout, low the cycle after the last rvalid.
- PRIO0=1, STARVE_MAX=8, req0 and req1 both held continuously -> gnt0 for 8 cycles, gnt1 on the 9th, then the pattern repeats; requester 1 is never starved beyond 9 cycles.
- PRIO0=0, both requesting continuously from reset -> grants alternate 0,1,0,1...; rvalids alternate with matching ROM data.
- Accept req1 at addr 0x3FFFF (max address), then assert rst_n low one cycle later -> after release, no rvalid1 pulse; rom_addr = 0; busy = 0.
- READ_LAT=2 rebuild, single req1 at addr 0x12345 -> rvalid1 exactly 3 cycles after gnt1 with ROM[0x12345].
